div_ghi_seq: RTL

- Sequencer for the Newton-Raphson reciprocal/divide datapath that computes sum_ghi / N.
- Accepts one division request via a start/done handshake and latches the operands.
- Drives the datapath's sub_state and en codes, and owns the iterate register reg_x that is fed back into the datapath.
- Captures the quotient and returns it to the bilateral-filter normalisation stage.

---
 rtl/div_seq_pkg.sv | 37 +++
 rtl/div_seq_xreg.sv | 38 +++
 rtl/div_ghi_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared codes and widths for the Newton-Raphson divide sequencer.
// Optional convergence early exit is enabled by DIV_SEQ_EARLY_EXIT_EN.
package div_seq_pkg;

  localparam int W_SUM = 27;
  localparam int W_N   = 20;
  localparam int W_X   = 27;
  localparam int W_DPX = 47;
  localparam int W_Q   = 54;

  localparam logic [W_X-1:0] X_SAT = 27'h7FF_FFFF;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LATCH    = 4'd1;
  localparam logic [3:0] CHECK    = 4'd2;
  localparam logic [3:0] SEED     = 4'd3;
  localparam logic [3:0] IT_FIRST = 4'd4;
  localparam logic [3:0] IT_LAST  = 4'd9;
  localparam logic [3:0] FINAL    = 4'd10;
  localparam logic [3:0] DONE     = 4'd11;

  typedef enum logic [3:0] {
    ST_IDLE  = IDLE,
    ST_LATCH = LATCH,
    ST_CHECK = CHECK,
    ST_SEED  = SEED,
    ST_IT4   = 4'd4,
    ST_IT5   = 4'd5,
    ST_IT6   = 4'd6,
    ST_IT7   = 4'd7,
    ST_IT8   = 4'd8,
    ST_IT9   = 4'd9,
    ST_FINAL = FINAL,
    ST_DONE  = DONE
  } state_t;

endpackage

// File: rtl/div_seq_xreg.sv
// Iterate register: saturating load of the datapath x output.
// Convergence flag only exists with DIV_SEQ_EARLY_EXIT_EN.
module div_seq_xreg
  import div_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W_DPX-1:0] dp_x,
`ifdef DIV_SEQ_EARLY_EXIT_EN
  output logic             conv,
`endif
  output logic [W_X-1:0]   reg_x
);

  function automatic logic [W_X-1:0] sat(
    input logic [W_DPX-1:0] v
  );
    return (v[W_DPX-1:W_X] != '0) ? X_SAT : v[W_X-1:0];
  endfunction

  logic [W_X-1:0] x_sat;

  assign x_sat = sat(dp_x);

`ifdef DIV_SEQ_EARLY_EXIT_EN
  assign conv = (x_sat == reg_x);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_x <= '0;
    end else if (load) begin
      reg_x <= x_sat;
    end
  end

endmodule

// File: rtl/div_ghi_seq.sv
// Sequencer for the sum_ghi / N Newton-Raphson divide datapath.
// Build with DIV_SEQ_EARLY_EXIT_EN to add the early_exit port.
module div_ghi_seq
  import div_seq_pkg::*;
#(
  parameter int NR_ITER = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W_SUM-1:0] sum_in,
  input  logic [W_N-1:0]   n_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [W_Q-1:0]   quotient,
`ifdef DIV_SEQ_EARLY_EXIT_EN
  output logic             early_exit,
`endif
  output logic [3:0]       sub_state,
  output logic             en,
  output logic [W_SUM-1:0] op_sum,
  output logic [W_N-1:0]   op_n,
  output logic [W_X-1:0]   reg_x,
  output logic [8:0]       reg_div,
  input  logic [W_DPX-1:0] dp_x,
  input  logic [W_Q-1:0]   dp_div
);

  localparam logic [3:0] LAST_IT = 4'(3 + 2 * NR_ITER);

  state_t     state;
  logic [3:0] code;
  logic       is_iter;
  logic       x_load;

  assign code    = state;
  assign is_iter = (code >= IT_FIRST) && (code <= IT_LAST);
  assign x_load  = (code == SEED) || (is_iter && code[0]);

`ifdef DIV_SEQ_EARLY_EXIT_EN
  logic x_conv;
  logic skip;

  assign early_exit = done & skip;
`endif

  div_seq_xreg u_xreg (
    .clk   (clk),
    .rst   (rst),
    .load  (x_load),
    .dp_x  (dp_x),
`ifdef DIV_SEQ_EARLY_EXIT_EN
    .conv  (x_conv),
`endif
    .reg_x (reg_x)
  );

  assign sub_state = code;
  assign busy      = (code != IDLE);
  assign en        = (code >= SEED) && (code <= FINAL);
  assign done      = (code == DONE);
  assign reg_div   = 9'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_sum      <= '0;
      op_n        <= '0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SEQ_EARLY_EXIT_EN
      skip        <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_LATCH;
            op_sum      <= sum_in;
            op_n        <= n_in;
            quotient    <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SEQ_EARLY_EXIT_EN
            skip        <= 1'b0;
`endif
          end
        end
        ST_LATCH: state <= ST_CHECK;
        ST_CHECK: begin
          if (op_n == '0) begin
            state       <= ST_DONE;
            div_by_zero <= 1'b1;
            quotient    <= '1;
          end else begin
            state <= ST_SEED;
          end
        end
        ST_SEED: state <= ST_IT4;
        ST_FINAL: begin
          quotient <= dp_div;
          state    <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          // iteration codes; anything outside 4..9 is recovered to IDLE
          if (!is_iter) begin
            state <= ST_IDLE;
          end else if (code == LAST_IT) begin
            state <= ST_FINAL;
`ifdef DIV_SEQ_EARLY_EXIT_EN
          end else if (code[0] && x_conv) begin
            state <= ST_FINAL;
            skip  <= 1'b1;
`endif
          end else begin
            state <= state_t'(code + 4'd1);
          end
        end
      endcase
    end
  end

endmodule
